// File: rtl/sysref_gen_pkg.sv
// Shared encodings for the PL-side SYSREF pulse generator: mode codes, FSM states
// and default field widths.
package sysref_gen_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 8;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_CONT    = 2'd1;
  localparam logic [1:0] MODE_BURST   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sysref_phase_counter.sv
// Phase counter for one SYSREF period: counts 0..last and wraps, flags the wrap
// edge and reports whether the next phase lies inside the high window.
module sysref_phase_counter
  import sysref_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  input  logic [CNT_W-1:0] hi_i,
  output logic             wrap_o,
  output logic             high_nxt_o
);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;

  assign wrap_o     = (phase_q == last_i);
  assign phase_d    = wrap_o ? '0 : phase_q + CNT_W'(1);
  assign high_nxt_o = (phase_d < hi_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      phase_q <= '0;
    end else if (en_i) begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sysref_pulse_gen.sv
// PL-side SYSREF source: registered pulse train with programmable period, high time
// and pulse count; continuous, burst and one-shot modes with a start/busy/done handshake.
module sysref_pulse_gen
  import sysref_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               pl_clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_cycles,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               sysref_out,
  output logic               sysref_rise
);

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  // High time is at least one cycle and always leaves one low cycle per period.
  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] h1;
    h1 = (h == '0) ? CNT_W'(1) : h;
    return (h1 > p - CNT_W'(1)) ? p - CNT_W'(1) : h1;
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   per_q, hi_q;
  logic [CNT_W-1:0]   per_d, hi_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q;
  logic               stop_pend_q;
  logic               busy_q, done_q, sysref_q, rise_q;
  logic               start_ok, wrap, high_nxt, term;

  assign per_d = clamp_period(period);
  assign hi_d  = clamp_high(high_cycles, per_d);
  assign rem_d = (mode == MODE_ONESHOT) ? BURST_W'(1) :
                 (burst_len == '0)      ? BURST_W'(1) : burst_len;

  assign start_ok = (state_q == ST_IDLE) && start && !stop && (mode != MODE_OFF);

  // A stop seen on the wrap edge itself ends the train at that same edge.
  assign term = wrap && (stop_pend_q || stop ||
                         ((mode_q != MODE_CONT) && (rem_q == BURST_W'(1))));

  sysref_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk_i      (pl_clk),
    .rst_i      (reset),
    .clr_i      (state_q != ST_RUN),
    .en_i       (state_q == ST_RUN),
    .last_i     (per_q - CNT_W'(1)),
    .hi_i       (hi_q),
    .wrap_o     (wrap),
    .high_nxt_o (high_nxt)
  );

  always_ff @(posedge pl_clk) begin
    if (start_ok) begin
      per_q <= per_d;
      hi_q  <= hi_d;
    end
  end

  always_ff @(posedge pl_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      rem_q       <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sysref_q    <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            state_q     <= ST_RUN;
            mode_q      <= mode;
            rem_q       <= rem_d;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b1;
            sysref_q    <= 1'b1;
            rise_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (term) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            sysref_q <= 1'b0;
            rise_q   <= 1'b0;
          end else begin
            sysref_q <= high_nxt;
            rise_q   <= wrap;
            if (stop) stop_pend_q <= 1'b1;
            if (wrap) rem_q <= rem_q - BURST_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sysref_out  = sysref_q;
  assign sysref_rise = rise_q;

endmodule

// File: tb/tb_sysref_pulse_gen.sv
// Scoreboard bench for sysref_pulse_gen: each launch queues the expected rise/fall/done
// cycles; a monitor process pops and compares every observed output event.
module tb_sysref_pulse_gen;
  import sysref_gen_pkg::*;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic               pl_clk = 1'b0;
  logic               reset  = 1'b1;
  logic [CNT_W-1:0]   period = '0;
  logic [CNT_W-1:0]   high_cycles = '0;
  logic [1:0]         mode = MODE_OFF;
  logic [BURST_W-1:0] burst_len = '0;
  logic               start = 1'b0;
  logic               stop  = 1'b0;
  logic               busy, done, sysref_out, sysref_rise;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  sysref_pulse_gen #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .pl_clk      (pl_clk),
    .reset       (reset),
    .period      (period),
    .high_cycles (high_cycles),
    .mode        (mode),
    .burst_len   (burst_len),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .sysref_out  (sysref_out),
    .sysref_rise (sysref_rise)
  );

  always #5 pl_clk = ~pl_clk;
  always @(posedge pl_clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_RISE: return "rise";
      EV_FALL: return "fall";
      default: return "done";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_train(input int t, input int p, input int h, input int n, input bit with_done);
    for (int k = 0; k < n; k++) begin
      expect_ev(EV_RISE, t + k * p);
      expect_ev(EV_FALL, t + k * p + h);
    end
    if (with_done) expect_ev(EV_DONE, t + n * p);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got event at cycle %0d expected none", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                 kname(kind), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  task automatic run_monitor();
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge pl_clk);
      if (sysref_rise || (sysref_out && !prev))
        chk("rise_strobe", int'(sysref_rise), int'(sysref_out && !prev));
      if (sysref_out && !prev) observe(EV_RISE);
      if (!sysref_out && prev) observe(EV_FALL);
      if (done) begin
        observe(EV_DONE);
        chk("busy_at_done", int'(busy), 0);
        chk("out_at_done", int'(sysref_out), 0);
      end
      prev = sysref_out;
    end
  endtask

  task automatic arm(input logic [1:0] m, input int per, input int hi, input int bl, output int t);
    @(negedge pl_clk);
    mode        = m;
    period      = CNT_W'(per);
    high_cycles = CNT_W'(hi);
    burst_len   = BURST_W'(bl);
    start       = 1'b1;
    t           = cyc + 1;
  endtask

  task automatic release_start();
    @(negedge pl_clk);
    start = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge pl_clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge pl_clk);
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(negedge pl_clk);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_out"},  int'(sysref_out), 0);
    chk({name, "_rise"}, int'(sysref_rise), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    fork
      run_monitor();
    join_none

    repeat (3) @(negedge pl_clk);
    chk_quiet("reset");
    reset = 1'b0;
    repeat (2) @(negedge pl_clk);

    // Burst of 4, P=10, H=3
    arm(MODE_BURST, 10, 3, 4, t);
    push_train(t, 10, 3, 4, 1'b1);
    release_start();
    at_cyc(t + 5);
    chk("burst_busy", int'(busy), 1);
    drain("burst", 60);

    // Continuous P=8, H=2, stop at phase 1 of the second pulse
    arm(MODE_CONT, 8, 2, 0, t);
    push_train(t, 8, 2, 2, 1'b0);
    expect_ev(EV_DONE, t + 16);
    release_start();
    at_cyc(t + 9);
    stop = 1'b1;
    @(negedge pl_clk);
    stop = 1'b0;
    drain("cont_stop", 40);

    // Clamping: period=0, high=0 -> P=2, H=1
    arm(MODE_BURST, 0, 0, 3, t);
    push_train(t, 2, 1, 3, 1'b1);
    release_start();
    drain("clamp_p2", 20);

    // Clamping: period=5, high=9 -> H=4
    arm(MODE_BURST, 5, 9, 2, t);
    push_train(t, 5, 4, 2, 1'b1);
    release_start();
    drain("clamp_h", 20);

    // One-shot ignores burst_len; start during RUN and DONE ignored
    arm(MODE_ONESHOT, 6, 2, 7, t);
    push_train(t, 6, 2, 1, 1'b1);
    release_start();
    at_cyc(t + 3);
    start = 1'b1;
    @(negedge pl_clk);
    start = 1'b0;
    at_cyc(t + 6);
    start = 1'b1;
    @(negedge pl_clk);
    start = 1'b0;
    drain("oneshot", 20);

    // Start and stop together in IDLE: no launch
    @(negedge pl_clk);
    mode = MODE_BURST; period = 16'd4; high_cycles = 16'd1; burst_len = 8'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge pl_clk);
    start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge pl_clk);
    chk("start_stop_busy", int'(busy), 0);
    drain("start_stop", 4);

    // Reset between pulse 2 and 3 of a 5-pulse burst
    arm(MODE_BURST, 6, 2, 5, t);
    push_train(t, 6, 2, 2, 1'b0);
    release_start();
    at_cyc(t + 9);
    reset = 1'b1;
    @(negedge pl_clk);
    chk_quiet("mid_reset");
    reset = 1'b0;
    drain("mid_reset", 20);

    arm(MODE_BURST, 6, 2, 5, t);
    push_train(t, 6, 2, 5, 1'b1);
    release_start();
    drain("after_reset", 60);

    // Inputs changed during RUN must not affect the train
    arm(MODE_BURST, 10, 3, 3, t);
    push_train(t, 10, 3, 3, 1'b1);
    release_start();
    period = 16'd4; high_cycles = 16'd1; burst_len = 8'd1; mode = MODE_CONT;
    drain("cfg_change", 50);

    // mode=0 start: no activity
    arm(MODE_OFF, 4, 1, 1, t);
    release_start();
    repeat (3) @(negedge pl_clk);
    chk("mode_off_busy", int'(busy), 0);
    drain("mode_off", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
